// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, reset PC, NOP encoding and the fetch-queue entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Fetch-entry FIFO with a registered head entry, flush and occupancy count.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  fetch_entry_t           wr_data,
  input  logic                   rd_en,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_head;
  logic          r_head_valid;

  logic          w_rd;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_left;
  logic [CW-1:0] w_count_nxt;

  // Entries remaining after this cycle's dequeue decide where the next head comes from.
  always_comb begin
    w_rd         = rd_en & r_head_valid;
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);
    w_count_left = r_count - CW'(w_rd);
    w_count_nxt  = w_count_left + CW'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else if (flush) begin
      r_rd_ptr     <= r_wr_ptr;
      r_count      <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_head_valid <= (w_count_nxt != '0);
      // An empty queue takes the incoming word as head; otherwise head holds when drained.
      if (wr_en && (w_count_left == '0)) begin
        r_head <= wr_data;
      end else if (w_count_left != '0) begin
        r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign head       = r_head;
  assign head_valid = r_head_valid;
  assign count      = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: owns the fetch PC, issues in-order word fetches,
// buffers responses with their PCs and drops stale responses after a redirect.
module instr_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [31:0]     RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_inflight_nxt;
  logic [OW-1:0]   w_occupancy;
  logic            w_gnt;
  logic            w_dropping;
  logic            w_accept;
  logic            w_deq;
  fetch_entry_t    w_wr_entry;
  fetch_entry_t    w_head;
  logic            w_head_valid;

  // Issue only while every outstanding fetch is guaranteed a queue slot.
  always_comb begin
    w_occupancy    = OW'(w_fifo_count) + OW'(r_inflight);
    mem_req        = !rst && !halt && !redirect && (w_occupancy < OW'(DEPTH));
    mem_addr       = word_align(r_fetch_pc);
    w_gnt          = mem_req && mem_gnt;
    w_inflight_nxt = r_inflight + CW'(w_gnt) - CW'(mem_rvalid);
    w_dropping     = (r_drop_cnt != '0);
    w_accept       = mem_rvalid && !w_dropping && !redirect;
    w_deq          = w_head_valid && !stall && !redirect;
    w_wr_entry     = fetch_entry_t'{pc: r_resp_pc, instr: mem_rdata};
  end

  // Redirect turns every response still owed by memory into one to discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= word_align(RESET_PC);
      r_resp_pc  <= word_align(RESET_PC);
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect) begin
      r_fetch_pc <= word_align(redirect_pc);
      r_resp_pc  <= word_align(redirect_pc);
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_inflight_nxt;
    end else begin
      if (w_gnt) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_accept) begin
        r_resp_pc <= r_resp_pc + XLEN'(4);
      end
      r_inflight <= w_inflight_nxt;
      if (mem_rvalid && w_dropping) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .wr_en     (w_accept),
    .wr_data   (w_wr_entry),
    .rd_en     (w_deq),
    .head      (w_head),
    .head_valid(w_head_valid),
    .count     (w_fifo_count)
  );

  assign out_valid = w_head_valid;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction-fetch front end between the shared instruction/data memory and the IF/ID pipeline register.
- Owns the fetch PC and issues in-order word fetches whenever the shared memory port grants a slot.
- Buffers returned instructions with their PCs in a small FIFO so the pipeline can stall without losing fetches.
- On a branch/jump redirect, flushes the queue and discards stale in-flight responses.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to the shared memory port.
- mem_addr  out  32  word address of the request (fetch_pc, bits [1:0] = 0).
- mem_gnt  in  1  request accepted this cycle; the data port has priority when it is busy.
- mem_rvalid  in  1  response valid; responses return in request order, at least one cycle after grant.
- mem_rdata  in  32  instruction word when mem_rvalid = 1.
- redirect  in  1  taken branch/jump or fence restart.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- halt  in  1  stop issuing new requests (break); in-flight responses are still accepted.
- stall  in  1  hazard unit is holding IF/ID; no dequeue this cycle.
- out_valid  out  1  head entry is valid.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - fetch_pc = RESET_PC.
  - count, inflight, drop_cnt, rd_ptr and wr_ptr = 0.
  - out_valid = 0; out_pc and out_instr = 0.
  - mem_req is 0 during the reset cycle.
  - Reset overrides redirect, gnt and rvalid in the same cycle. Responses arriving after reset are ignored only when drop_cnt covers them; the memory is reset with the same rst.
- Request (combinational):
  - mem_req = !rst & !halt & !redirect & (count + inflight < DEPTH).
  - mem_addr = fetch_pc.
- Grant: mem_req & mem_gnt -> fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and inflight += 1.
- Response: mem_rvalid decrements inflight.
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: write {resp_pc, mem_rdata} at wr_ptr and increment count.
  - resp_pc is kept in a separate PC-tag counter that advances by 4 per accepted response.
- Dequeue: out_valid & !stall -> rd_ptr advances and count decrements.
  - A simultaneous enqueue and dequeue leaves count unchanged.
- Output timing:
  - out_* reflect the head entry registered-from-FIFO, with no bypass.
  - A response is visible on out_valid the cycle after mem_rvalid.
- Redirect (highest priority below rst):
  - count = 0; rd_ptr = wr_ptr; out_valid = 0 next cycle.
  - fetch_pc and resp_pc tag = redirect_pc & ~3.
  - drop_cnt = inflight + (grant this cycle ? 1 : 0) − (rvalid this cycle ? 1 : 0), counting only responses not yet consumed.
  - A dequeue in the same cycle is ignored.
- Latency: redirect in cycle 0 -> mem_req in cycle 1; with gnt in cycle 1 and rvalid in cycle 2, out_valid = 1 in cycle 3.
- Boundaries:
  - Full (count + inflight = DEPTH): mem_req = 0.
  - Empty: out_valid = 0, and out_pc/out_instr hold their last values.
  - Overflow cannot occur by construction. The verification bench asserts count ≤ DEPTH and inflight + count ≤ DEPTH.
  - halt with redirect: the redirect still updates fetch_pc, but nothing issues until halt = 0.
- Width rules:
  - count and inflight are $clog2(DEPTH)+1 bits.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN = 32;
  - RESET_PC;
  - INSTR_NOP = 32'h0000_0013, used by downstream bubble insertion.
- One sub-module: sync_fifo (DEPTH × 64-bit storage, flush input, count output). The request and drop logic stay in the top-level module.

Test Plan:
- Reset then mem_gnt = 1 always, 1-cycle rvalid, stall = 0 -> out_pc sequence 0x0, 0x4, 0x8, …; first out_valid 3 cycles after rst falls.
- stall held high for 10 cycles -> exactly DEPTH = 4 entries buffered; mem_req = 0 while full. Release -> pcs continue 0x10, 0x14 in order, with no duplicates or gaps.
- Redirect to 0x40 while 2 fetches are in flight -> both stale responses dropped; next out_pc = 0x40, with its instruction being the word at 0x40.
- mem_gnt low for 5 cycles (data access priority) -> mem_addr holds constant; no entry is lost or duplicated; out_valid gaps only.
- halt asserted at fetch_pc 0x20 -> queue drains; no request with addr ≥ 0x20 issues. Deassert -> fetch resumes at 0x20.
- Redirect to 0xFFFF_FFFC, then enqueue two -> out_pc 0xFFFF_FFFC, then 0x0.
- rst asserted mid-stream with the queue full -> next cycle out_valid = 0; mem_req resumes at RESET_PC.
